// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Data-memory access unit between the core load/store port and a
//   single-port synchronous word-wide SRAM. Each accepted core request becomes
//   one byte-enabled SRAM cycle. Sub-word stores are lane-steered. Sub-word
//   loads are lane-selected and then sign- or zero-extended. The core is
//   stalled for the SRAM latency. Malformed, misaligned or out-of-range
//   requests are flagged on memError and never reach the SRAM.
//
// Parameters
//   WAIT_STATES  extra SRAM read-latency cycles (0..15)
//   RAM_AW       SRAM word-address width (RAM = 4*2^RAM_AW bytes)
//
// Ports
//   CLK         clock, rising edge
//   RES         synchronous active-high reset
//   memRead     core load request
//   memWrite    core store request
//   memAddr     byte address
//   memDataIn   store data, right-aligned
//   func3       RISC-V width/sign code of the access
//   memDataOut  extended load result, held until the next load completes
//   memStall    core must hold its request and pipeline (combinational)
//   memError    one-cycle pulse when a request is rejected
//   ramEn       SRAM access strobe
//   ramWe       SRAM byte write enables (0 = read)
//   ramAddr     SRAM word address
//   ramWdata    lane-steered store data
//   ramRdata    SRAM read data
module mem_access_unit #(
  parameter int WAIT_STATES = 1,
  parameter int RAM_AW      = 10
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [31:0]       memAddr,
  input  logic [31:0]       memDataIn,
  input  logic [2:0]        func3,
  output logic [31:0]       memDataOut,
  output logic              memStall,
  output logic              memError,
  output logic              ramEn,
  output logic [3:0]        ramWe,
  output logic [RAM_AW-1:0] ramAddr,
  output logic [31:0]       ramWdata,
  input  logic [31:0]       ramRdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        lane_q;
  logic [2:0]        func3_q;
  logic              store_q;
  logic              ram_en_q;
  logic [3:0]        ram_we_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;
  logic [31:0]       dout_q;
  logic              err_q;

  // ---------------------------------------------------------------------------
  // Request validation (evaluated in the accept cycle)
  // ---------------------------------------------------------------------------
  logic req;
  logic accept_state;
  logic f3_ok;
  logic align_ok;
  logic range_ok;
  logic req_valid;

  assign req          = memRead | memWrite;
  assign accept_state = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    f3_ok = 1'b0;
    if (memRead && memWrite) begin
      f3_ok = 1'b0;
    end else if (memRead) begin
      f3_ok = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
              (func3 == 3'b100) || (func3 == 3'b101);
    end else if (memWrite) begin
      f3_ok = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    end
  end

  always_comb begin
    case (func3[1:0])
      2'b01:   align_ok = ~memAddr[0];
      2'b10:   align_ok = (memAddr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  // Any address bit above the SRAM byte range makes the request out of range.
  assign range_ok  = ((memAddr >> (RAM_AW + 2)) == '0);
  assign req_valid = req && !(memRead && memWrite) && f3_ok && align_ok && range_ok;

  // ---------------------------------------------------------------------------
  // Store lane steering, computed from the live request and registered on accept
  // ---------------------------------------------------------------------------
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  always_comb begin
    case (func3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << memAddr[1:0];
        st_wdata = {4{memDataIn[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << memAddr[1:0];
        st_wdata = {2{memDataIn[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = memDataIn;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane selection and extension from the SRAM read data
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = ramRdata[7:0];
      2'd1:    ld_byte = ramRdata[15:8];
      2'd2:    ld_byte = ramRdata[23:16];
      default: ld_byte = ramRdata[31:24];
    endcase
    ld_half = lane_q[1] ? ramRdata[31:16] : ramRdata[15:0];
    case (func3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = ramRdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          state_d = req_valid ? S_ACCESS : S_ERROR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (store_q) begin
          state_d = S_DONE;
        end else if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= rather than == so a corrupted zero count cannot lock the unit up.
        if (cnt_q <= 4'd1) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: state_d = S_DONE;
      S_ERROR:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // SRAM outputs are loaded on the transition into ACCESS and cleared on any
  // other transition, so they are registered yet only non-zero in ACCESS.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      func3_q     <= '0;
      store_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      dout_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= (state_d == S_ERROR);
      ram_en_q <= (state_d == S_ACCESS);
      if (state_d == S_ACCESS) begin
        lane_q      <= memAddr[1:0];
        func3_q     <= func3;
        store_q     <= memWrite;
        ram_addr_q  <= memAddr[RAM_AW+1:2];
        ram_we_q    <= memWrite ? st_we : 4'b0000;
        ram_wdata_q <= memWrite ? st_wdata : '0;
      end else begin
        ram_addr_q  <= '0;
        ram_we_q    <= '0;
        ram_wdata_q <= '0;
      end
      if (state_q == S_CAPTURE) begin
        dout_q <= ld_ext;
      end
    end
  end

  assign memStall   = (accept_state && req_valid) ||
                      (state_q == S_ACCESS) || (state_q == S_WAIT) ||
                      (state_q == S_CAPTURE);
  assign memError   = err_q;
  assign memDataOut = dout_q;
  assign ramEn      = ram_en_q;
  assign ramWe      = ram_we_q;
  assign ramAddr    = ram_addr_q;
  assign ramWdata   = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. Three instances with WAIT_STATES 0, 1 and 3
// each talk to their own SRAM model. A byte-array reference memory and the
// stated cycle timing provide all expected values.
module tb_mem_access_unit;

  localparam int AW = 10;

  logic clk;
  logic        res_s  [3];
  logic        rd_s   [3];
  logic        wr_s   [3];
  logic [31:0] addr_s [3];
  logic [31:0] din_s  [3];
  logic [2:0]  f3_s   [3];
  logic [31:0] dout_s [3];
  logic        stall_s[3];
  logic        err_s  [3];
  logic        en_s   [3];
  logic [3:0]  we_s   [3];
  logic [AW-1:0] ra_s [3];
  logic [31:0] wd_s   [3];

  int checks = 0;
  int errors = 0;

  // Reference model: byte-addressed memory and last load result per instance.
  logic [7:0]  refm      [3][4096];
  logic [31:0] last_dout [3];

  // Per-cycle observation traces filled by run_seq.
  logic        st_tr [64];
  logic        en_tr [64];
  logic        er_tr [64];
  logic [3:0]  we_tr [64];
  logic [AW-1:0] ad_tr [64];
  logic [31:0] wd_tr [64];
  logic [31:0] do_tr [64];

  typedef struct {
    bit          rd;
    bit          wr;
    bit          res;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    int          hold;
  } req_t;
  req_t seq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [31:0] mem [1024];
    logic [31:0] rd_data;
    logic [31:0] rdata;
    int          rd_cnt;

    mem_access_unit #(.WAIT_STATES(W), .RAM_AW(AW)) u_dut (
      .CLK(clk), .RES(res_s[g]), .memRead(rd_s[g]), .memWrite(wr_s[g]),
      .memAddr(addr_s[g]), .memDataIn(din_s[g]), .func3(f3_s[g]),
      .memDataOut(dout_s[g]), .memStall(stall_s[g]), .memError(err_s[g]),
      .ramEn(en_s[g]), .ramWe(we_s[g]), .ramAddr(ra_s[g]),
      .ramWdata(wd_s[g]), .ramRdata(rdata)
    );

    // Read data is only meaningful exactly 1+W cycles after the strobe.
    assign rdata = (rd_cnt == 1) ? rd_data : 32'hBAD0_BAD0;

    initial begin
      rd_cnt  = 0;
      rd_data = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
      if (en_s[g] && we_s[g] != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (we_s[g][b]) mem[ra_s[g]][8*b +: 8] <= wd_s[g][8*b +: 8];
      end
      if (en_s[g] && we_s[g] == 4'b0000) begin
        rd_data <= mem[ra_s[g]];
        rd_cnt  <= W + 1;
      end else if (rd_cnt != 0) begin
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_valid(input bit rd, input bit wr,
                                   input logic [31:0] a, input logic [2:0] f3);
    int sz;
    if (rd == wr) return 1'b0;
    if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5))
      return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    sz = size_of(f3);
    if ((a % sz) != 0) return 1'b0;
    if (a >= 32'd4096) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input int k, input logic [31:0] a,
                                           input logic [2:0] f3);
    int sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = '0;
    for (int i = 0; i < sz; i++) v = v | (32'(refm[k][a + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic ref_store(input int k, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f3);
    for (int i = 0; i < size_of(f3); i++) refm[k][a + i] = d[8*i +: 8];
  endtask

  task automatic push(input bit rd, input bit wr, input bit res,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input int hold);
    req_t e;
    e.rd = rd; e.wr = wr; e.res = res; e.addr = a; e.data = d;
    e.f3 = f3; e.hold = hold;
    seq.push_back(e);
  endtask

  task automatic drive_idle(input int k);
    res_s[k] = 1'b0; rd_s[k] = 1'b0; wr_s[k] = 1'b0;
    addr_s[k] = '0; din_s[k] = '0; f3_s[k] = '0;
  endtask

  // Plays the queued requests on instance k, each held for its hold count,
  // then idles; records ncyc cycles of outputs sampled at the falling edge.
  // Entry and exit are 1 time unit after a rising edge.
  task automatic run_seq(input int k, input int ncyc);
    int idx;
    int rem;
    idx = 0;
    rem = (seq.size() > 0) ? seq[0].hold : 0;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < seq.size()) begin
        res_s[k] = seq[idx].res; rd_s[k] = seq[idx].rd; wr_s[k] = seq[idx].wr;
        addr_s[k] = seq[idx].addr; din_s[k] = seq[idx].data; f3_s[k] = seq[idx].f3;
      end else begin
        drive_idle(k);
      end
      @(negedge clk);
      st_tr[c] = stall_s[k]; en_tr[c] = en_s[k]; er_tr[c] = err_s[k];
      we_tr[c] = we_s[k]; ad_tr[c] = ra_s[k]; wd_tr[c] = wd_s[k];
      do_tr[c] = dout_s[k];
      @(posedge clk);
      #1;
      if (idx < seq.size()) begin
        rem--;
        if (rem == 0) begin
          idx++;
          if (idx < seq.size()) rem = seq[idx].hold;
        end
      end
    end
    drive_idle(k);
    seq.delete();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (stall_s[k] !== 1'b0 || en_s[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_idle k%0d c%0d: stall=%b ramEn=%b, required 0/0", k, c, stall_s[k], en_s[k]);
        end
        if (c == 0) begin
          checks++;
          if (dout_s[k] !== 32'd0 || err_s[k] !== 1'b0 || we_s[k] !== 4'd0 ||
              ra_s[k] !== '0 || wd_s[k] !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs k%0d: dout=%h err=%b we=%b addr=%h wdata=%h, required all 0",
                     k, dout_s[k], err_s[k], we_s[k], ra_s[k], wd_s[k]);
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_byte();
    int k;
    k = 1;
    push(0, 1, 0, 32'h6, 32'h0000_00A5, 3'b000, 2);
    run_seq(k, 4);
    ref_store(k, 32'h6, 32'h0000_00A5, 3'b000);
    checks++;
    if (st_tr[0] !== 1'b1 || st_tr[1] !== 1'b1 || st_tr[2] !== 1'b0) begin
      errors++;
      $display("FAIL sb_stall: got %b%b%b, required 110", st_tr[0], st_tr[1], st_tr[2]);
    end
    checks++;
    if (en_tr[1] !== 1'b1 || we_tr[1] !== 4'b0100 || ad_tr[1] !== 10'd1 || wd_tr[1] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL sb_ram: en=%b we=%b addr=%h wdata=%h, required 1 0100 001 a5a5a5a5",
               en_tr[1], we_tr[1], ad_tr[1], wd_tr[1]);
    end
    checks++;
    if (en_tr[0] !== 1'b0 || en_tr[2] !== 1'b0 || en_tr[3] !== 1'b0) begin
      errors++;
      $display("FAIL sb_single_strobe: en c0/c2/c3 = %b%b%b, required 000", en_tr[0], en_tr[2], en_tr[3]);
    end

    push(1, 0, 0, 32'h6, 32'h0, 3'b000, 4);
    run_seq(k, 6);
    checks++;
    if (st_tr[3] !== 1'b1 || st_tr[4] !== 1'b0 || do_tr[4] !== 32'hFFFF_FFA5) begin
      errors++;
      $display("FAIL lb_result: stall@3=%b stall@4=%b dout@4=%h, required 1 0 ffffffa5", st_tr[3], st_tr[4], do_tr[4]);
    end
    checks++;
    if (en_tr[1] !== 1'b1 || we_tr[1] !== 4'b0000) begin
      errors++;
      $display("FAIL lb_ram: en=%b we=%b, required 1 0000", en_tr[1], we_tr[1]);
    end

    push(1, 0, 0, 32'h6, 32'h0, 3'b100, 4);
    run_seq(k, 6);
    checks++;
    if (do_tr[4] !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL lbu_result: got %h, required 000000a5", do_tr[4]);
    end
    last_dout[k] = 32'h0000_00A5;
  endtask

  task automatic test_half_word();
    int k;
    k = 0;
    push(0, 1, 0, 32'h10, 32'h8001_7FFE, 3'b010, 2);
    run_seq(k, 3);
    ref_store(k, 32'h10, 32'h8001_7FFE, 3'b010);
    checks++;
    if (we_tr[1] !== 4'b1111 || wd_tr[1] !== 32'h8001_7FFE || ad_tr[1] !== 10'd4) begin
      errors++;
      $display("FAIL sw_ram: we=%b wdata=%h addr=%h, required 1111 80017ffe 004", we_tr[1], wd_tr[1], ad_tr[1]);
    end
    push(1, 0, 0, 32'h12, 32'h0, 3'b001, 3);
    run_seq(k, 4);
    checks++;
    if (do_tr[3] !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL lh_result: got %h, required ffff8001", do_tr[3]);
    end
    push(1, 0, 0, 32'h10, 32'h0, 3'b101, 3);
    run_seq(k, 4);
    checks++;
    if (do_tr[3] !== 32'h0000_7FFE) begin
      errors++;
      $display("FAIL lhu_result: got %h, required 00007ffe", do_tr[3]);
    end
    push(1, 0, 0, 32'h10, 32'h0, 3'b010, 3);
    run_seq(k, 4);
    checks++;
    if (st_tr[2] !== 1'b1 || st_tr[3] !== 1'b0 || do_tr[3] !== 32'h8001_7FFE) begin
      errors++;
      $display("FAIL lw_t3: stall@2=%b stall@3=%b dout@3=%h, required 1 0 80017ffe", st_tr[2], st_tr[3], do_tr[3]);
    end
    last_dout[k] = 32'h8001_7FFE;
  endtask

  task automatic test_errors();
    int k;
    bit          c_rd[5] = '{1, 0, 1, 1, 1};
    bit          c_wr[5] = '{0, 1, 0, 0, 1};
    logic [31:0] c_ad[5] = '{32'h2, 32'h1, 32'h0, 32'h1000, 32'h0};
    logic [2:0]  c_f3[5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b010};
    k = 1;
    for (int i = 0; i < 5; i++) begin
      push(c_rd[i], c_wr[i], 0, c_ad[i], 32'hFFFF_FFFF, c_f3[i], 1);
      run_seq(k, 3);
      checks++;
      if (er_tr[0] !== 1'b0 || er_tr[1] !== 1'b1 || er_tr[2] !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse case%0d: memError c0..2=%b%b%b, required 010", i, er_tr[0], er_tr[1], er_tr[2]);
      end
      checks++;
      if (st_tr[0] !== 1'b0 || st_tr[1] !== 1'b0 || en_tr[0] !== 1'b0 || en_tr[1] !== 1'b0 || en_tr[2] !== 1'b0) begin
        errors++;
        $display("FAIL err_no_access case%0d: stall=%b%b en=%b%b%b, required stall 00 en 000",
                 i, st_tr[0], st_tr[1], en_tr[0], en_tr[1], en_tr[2]);
      end
      checks++;
      if (do_tr[2] !== last_dout[k]) begin
        errors++;
        $display("FAIL err_dout_hold case%0d: got %h, required %h", i, do_tr[2], last_dout[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [31:0] d;
    k = 0;
    d = $urandom();
    push(0, 1, 0, 32'h20, d, 3'b010, 2);
    push(1, 0, 0, 32'h20, 32'h0, 3'b010, 3);
    run_seq(k, 7);
    ref_store(k, 32'h20, d, 3'b010);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (st_tr[c] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stall_gap c%0d: got %b, required 1", c, st_tr[c]);
      end
    end
    checks++;
    if (st_tr[5] !== 1'b0 || do_tr[5] !== ref_load(k, 32'h20, 3'b010)) begin
      errors++;
      $display("FAIL b2b_result: stall=%b dout=%h, required 0 %h", st_tr[5], do_tr[5], ref_load(k, 32'h20, 3'b010));
    end
    checks++;
    if (en_tr[1] !== 1'b1 || en_tr[2] !== 1'b0 || en_tr[3] !== 1'b1 || we_tr[3] !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_strobes: en c1/c2/c3=%b%b%b we@3=%b, required 101 0000", en_tr[1], en_tr[2], en_tr[3], we_tr[3]);
    end
    last_dout[k] = d;
  endtask

  task automatic test_reset_mid();
    int k;
    logic [31:0] y;
    k = 2;
    y = $urandom() | 32'h0100_0001;
    push(0, 1, 0, 32'h44, y, 3'b010, 2);
    push(1, 0, 0, 32'h44, 32'h0, 3'b010, 6);
    run_seq(k, 9);
    ref_store(k, 32'h44, y, 3'b010);
    checks++;
    if (do_tr[8] !== y) begin
      errors++;
      $display("FAIL rmid_preload: got %h, required %h", do_tr[8], y);
    end
    // Reset is raised in the first WAIT cycle (cycle 2) of the next load.
    push(1, 0, 0, 32'h44, 32'h0, 3'b010, 2);
    push(0, 0, 1, 32'h0, 32'h0, 3'b000, 1);
    run_seq(k, 10);
    checks++;
    if (st_tr[2] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_in_wait: stall@2=%b, required 1", st_tr[2]);
    end
    for (int c = 3; c < 10; c++) begin
      checks++;
      if (do_tr[c] !== 32'd0 || st_tr[c] !== 1'b0 || en_tr[c] !== 1'b0) begin
        errors++;
        $display("FAIL rmid_abort c%0d: dout=%h stall=%b en=%b, required 0 0 0", c, do_tr[c], st_tr[c], en_tr[c]);
      end
    end
    last_dout[k] = '0;
    push(1, 0, 0, 32'h44, 32'h0, 3'b010, 6);
    run_seq(k, 8);
    checks++;
    if (st_tr[5] !== 1'b1 || st_tr[6] !== 1'b0 || do_tr[6] !== y) begin
      errors++;
      $display("FAIL rmid_recover: stall@5=%b stall@6=%b dout=%h, required 1 0 %h", st_tr[5], st_tr[6], do_tr[6], y);
    end
    last_dout[k] = y;
  endtask

  task automatic test_random();
    logic [2:0] lf[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 24; n++) begin
        bit          rd, wr, ok;
        logic [31:0] a, d, exp_v, exp_wd;
        logic [2:0]  f3;
        logic [3:0]  exp_we;
        int          kind, hold, sz, nen;
        kind = $urandom_range(0, 9);
        d    = $urandom();
        if (kind == 0) begin
          rd = ($urandom_range(0, 1) == 1);
          wr = !rd || ($urandom_range(0, 1) == 1);
          f3 = 3'($urandom_range(0, 7));
          a  = $urandom_range(0, 63);
          if ($urandom_range(0, 1) == 1) a = a | (32'h1000 << $urandom_range(0, 19));
        end else begin
          rd = (kind < 5);
          wr = !rd;
          f3 = rd ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
          sz = size_of(f3);
          a  = 32'($urandom_range(0, 63)) & ~32'(sz - 1);
        end
        ok   = ref_valid(rd, wr, a, f3);
        hold = !ok ? 1 : (wr ? 2 : 3 + wait_of(k));
        push(rd, wr, 0, a, d, f3, hold);
        run_seq(k, hold + 2);
        nen = 0;
        for (int c = 0; c < hold + 2; c++) nen += int'(en_tr[c]);
        if (!ok) begin
          checks++;
          if (er_tr[1] !== 1'b1 || st_tr[0] !== 1'b0 || nen != 0 || do_tr[2] !== last_dout[k]) begin
            errors++;
            $display("FAIL rnd_err k%0d n%0d a=%h f3=%0d: err=%b stall=%b nen=%0d dout=%h, required 1 0 0 %h",
                     k, n, a, f3, er_tr[1], st_tr[0], nen, do_tr[2], last_dout[k]);
          end
        end else begin
          checks++;
          if (st_tr[hold-1] !== 1'b1 || st_tr[hold] !== 1'b0 || nen != 1 || en_tr[1] !== 1'b1 ||
              ad_tr[1] !== a[AW+1:2] || er_tr[1] !== 1'b0) begin
            errors++;
            $display("FAIL rnd_timing k%0d n%0d: stall end=%b%b nen=%0d en@1=%b addr=%h err=%b, required 10 1 1 %h 0",
                     k, n, st_tr[hold-1], st_tr[hold], nen, en_tr[1], ad_tr[1], er_tr[1], a[AW+1:2]);
          end
          sz = size_of(f3);
          if (wr) begin
            exp_we = 4'(((1 << sz) - 1) << a[1:0]);
            exp_wd = (sz == 1) ? {4{d[7:0]}} : ((sz == 2) ? {2{d[15:0]}} : d);
            ref_store(k, a, d, f3);
            checks++;
            if (we_tr[1] !== exp_we || wd_tr[1] !== exp_wd || do_tr[hold] !== last_dout[k]) begin
              errors++;
              $display("FAIL rnd_store k%0d n%0d: we=%b wdata=%h dout=%h, required %b %h %h",
                       k, n, we_tr[1], wd_tr[1], do_tr[hold], exp_we, exp_wd, last_dout[k]);
            end
          end else begin
            exp_v = ref_load(k, a, f3);
            checks++;
            if (we_tr[1] !== 4'b0000 || do_tr[hold] !== exp_v) begin
              errors++;
              $display("FAIL rnd_load k%0d n%0d a=%h f3=%0d: we=%b dout=%h, required 0000 %h",
                       k, n, a, f3, we_tr[1], do_tr[hold], exp_v);
            end
            last_dout[k] = exp_v;
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      drive_idle(k);
      res_s[k]     = 1'b1;
      last_dout[k] = '0;
      for (int i = 0; i < 4096; i++) refm[k][i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) res_s[k] = 1'b0;
    test_reset();
    test_byte();
    test_half_word();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit between the core's load/store port (`memRead`, `memWrite`, `memAddr`, `memDataIn`) and a single-port synchronous word-wide SRAM. It turns each core request into byte-enabled SRAM transactions. It handles RISC-V sub-word loads and stores, including lane steering and sign/zero extension. It stalls the core for the SRAM latency and flags misaligned, out-of-range or malformed requests instead of issuing them.

## Interface
- `WAIT_STATES`, 1, extra SRAM read-latency cycles, range 0..15
- `RAM_AW`, 10, SRAM word-address width (RAM size = 4·2^RAM_AW bytes)

- `CLK`  in  1  clock, all state updates on rising edge
- `RES`  in  1  reset, synchronous, active-high
- `memRead`  in  1  core load request
- `memWrite`  in  1  core store request
- `memAddr`  in  32  byte address
- `memDataIn`  in  32  store data, right-aligned
- `func3`  in  3  RISC-V width/sign code of the load or store
- `memDataOut`  out  32  extended load result
- `memStall`  out  1  core must hold its request and pipeline
- `memError`  out  1  one-cycle pulse, request rejected
- `ramEn`  out  1  SRAM access strobe
- `ramWe`  out  4  SRAM byte write enables; 0 means read
- `ramAddr`  out  RAM_AW  SRAM word address = `memAddr[RAM_AW+1:2]`
- `ramWdata`  out  32  lane-steered store data
- `ramRdata`  in  32  SRAM read data

## Operation
- States: IDLE, ACCESS, WAIT, CAPTURE, DONE, ERROR. Reset enters IDLE.
- Requests are accepted in IDLE and DONE only.
- Validation is done in the accept cycle. A request is invalid if any of these holds:
  - `memRead` and `memWrite` are both high.
  - Load `func3` is not in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Store `func3` is not in {000 SB, 001 SH, 010 SW}.
  - Halfword access with `memAddr[0]=1`.
  - Word access with `memAddr[1:0]≠0`.
  - `memAddr[31:RAM_AW+2]≠0`.
- Invalid request goes to ERROR. No SRAM access is issued. `memError=1` for that one cycle, then IDLE.
- Valid request latches address, `func3`, store data and direction, then goes to ACCESS.
- ACCESS, one cycle:
  - Outputs `ramEn=1`, `ramAddr`, `ramWe`, `ramWdata` from registers.
  - SB: `ramWe=4'b0001<<addr[1:0]`, `ramWdata={4{memDataIn[7:0]}}`.
  - SH: `ramWe=4'b0011<<addr[1:0]`, `ramWdata={2{memDataIn[15:0]}}`.
  - SW: `ramWe=4'b1111`.
  - Load: `ramWe=0`.
  - Next state: store → DONE; load → WAIT if `WAIT_STATES>0`, else CAPTURE.
- WAIT: a 4-bit down-counter is loaded with `WAIT_STATES` on entry. `ramEn=0`. Goes to CAPTURE when the counter reaches 1.
- CAPTURE:
  - Selects lane `addr[1:0]` (halfword: `addr[1]`) from `ramRdata`.
  - Sign-extends (LB/LH) or zero-extends (LBU/LHU) and registers the result into `memDataOut`.
  - Goes to DONE.
- DONE, one cycle:
  - `memStall=0`.
  - A load's result is valid on `memDataOut`.
  - A request present this cycle is treated as a new request (back-to-back).
- `memDataOut` holds its value until the next load's CAPTURE. Stores and errors do not change it.
- `ramEn`, `ramWe`, `ramAddr` and `ramWdata` are zero outside ACCESS.

## Timing
- `memStall` is combinational:
  - 1 when (state is IDLE or DONE) and a valid request is present.
  - 1 in ACCESS, WAIT and CAPTURE.
  - 0 otherwise, including ERROR and the invalid-request accept cycle.
- Request accepted at cycle T:
  - Load: `memStall` is high T..T+2+W. `memDataOut` is valid and `memStall=0` at T+3+W (W=`WAIT_STATES`).
  - Store: `memStall` is high T..T+1. `ramEn` is high at T+1. DONE at T+2.
  - Invalid request: `memError` is high at T+1 only. `memStall` is 0 throughout.
- SRAM contract: `ramRdata` is valid in the cycle that is 1+W cycles after the `ramEn` cycle.
- Reset values: `memDataOut=0`, `memError=0`, `ramEn=0`, `ramWe=0`, `ramAddr=0`, `ramWdata=0`, counter 0. `memStall=0` absent a request.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs at reset values.
  - A store already strobed in ACCESS is committed by the SRAM.
  - No further SRAM cycles are issued for the aborted request.
  - A pending load result is discarded.

## Test plan
- Reset: `RES` high for 2 cycles → all outputs 0. Then `memRead=0`, `memWrite=0` → `memStall=0` and `ramEn=0` indefinitely.
- Byte store/load, W=1:
  - SB addr 0x00000006 data 0x000000A5 → at T+1 `ramEn=1`, `ramWe=0100`, `ramAddr=1`, `ramWdata=0xA5A5A5A5`.
  - LB same address → `memDataOut=0xFFFFFFA5` at T+4.
  - LBU same address → `memDataOut=0x000000A5`.
- Halfword and word, W=0:
  - SW 0x00000010 ← 0x8001_7FFE.
  - LH 0x12 → `0xFFFF8001`.
  - LHU 0x10 → `0x00007FFE`.
  - LW 0x10 → `0x80017FFE`, result valid at T+3.
- Errors:
  - LW addr 0x2 → `memError` pulse at T+1 and no `ramEn`.
  - SH addr 0x1 → same.
  - `func3=011` load → same.
  - Addr 0x00001000 with `RAM_AW=10` → same.
  - `memRead` and `memWrite` together → same.
  - `memDataOut` unchanged in every case.
- Back-to-back: hold a new LW request in the DONE cycle of a store → accepted immediately, `memStall` stays high with no gap, result correct.
- Reset mid-load: assert `RES` during WAIT with W=3 → IDLE next cycle, `memDataOut=0`, no CAPTURE. A subsequent LW completes normally.
